// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives the 16 input vectors of a 4-input boolean block
// in order ({x,y,w,z} = index, x is the MSB). It samples s_in once per vector
// after SETTLE cycles, collects the truth table and reports how it differs
// from EXPECTED.
module truth_table_sweeper #(
  parameter logic [15:0] EXPECTED = 16'h77B0,
  parameter int          SETTLE   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        s_in,
  output logic        x,
  output logic        y,
  output logic        w,
  output logic        z,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] table_out,
  output logic [4:0]  mismatch_cnt,
  output logic [3:0]  first_fail,
  output logic        fail_valid
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state;
  logic [3:0] idx;
  logic [3:0] wait_cnt;
  logic [3:0] stim;

  // Mismatch of the vector being sampled and the count that results from it.
  logic       miss;
  logic [4:0] cnt_next;

  // Adds a single mismatch to the running count.
  function automatic logic [4:0] count_step(input logic [4:0] cnt, input logic hit);
    count_step = cnt + {4'd0, hit};
  endfunction

  assign miss     = (s_in != EXPECTED[idx]);
  assign cnt_next = count_step(mismatch_cnt, miss);

  assign {x, y, w, z} = stim;

  // Sweep controller: all outputs are registered; results hold until the next accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= 4'd0;
      wait_cnt     <= 4'd0;
      stim         <= 4'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      table_out    <= 16'd0;
      mismatch_cnt <= 5'd0;
      first_fail   <= 4'd0;
      fail_valid   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          stim <= 4'd0;
          if (start) begin
            table_out    <= 16'd0;
            mismatch_cnt <= 5'd0;
            first_fail   <= 4'd0;
            fail_valid   <= 1'b0;
            pass         <= 1'b0;
            idx          <= 4'd0;
            wait_cnt     <= 4'd0;
            busy         <= 1'b1;
            state        <= DRIVE;
          end
        end

        DRIVE: begin
          // Hold the vector for SETTLE edges before sampling.
          if (wait_cnt == SETTLE_LAST) begin
            wait_cnt <= 4'd0;
            state    <= SAMPLE;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end

        SAMPLE: begin
          table_out[idx] <= s_in;
          mismatch_cnt   <= cnt_next;
          // Only the first mismatch of a sweep records its index.
          if (miss && !fail_valid) begin
            first_fail <= idx;
            fail_valid <= 1'b1;
          end
          if (idx == 4'd15) begin
            // pass must include the verdict on the final vector.
            pass  <= (cnt_next == 5'd0);
            done  <= 1'b1;
            busy  <= 1'b0;
            stim  <= 4'd0;
            state <= DONE;
          end else begin
            idx   <= idx + 4'd1;
            stim  <= idx + 4'd1;
            state <= DRIVE;
          end
        end

        DONE: begin
          // start here is deliberately ignored; it is only honoured in IDLE.
          done  <= 1'b0;
          stim  <= 4'd0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
